fb_rect_writer: RTL and testbench

Framebuffer writer: the write-side counterpart to the VGA scan-out path, which reads the 1-bit pixel memory. Accepts rectangle-fill commands through a valid/ready handshake. Emits one 1-bit pixel write per clock into the pixel memory, using the same linear addressing as the scan-out: addr = x + STRIDE*y. Sits between the drawing/control logic and the memory write port, in the pixel clock domain.

---
 rtl/fb_rect_writer.sv | 174 +++++++++++++++++
 tb/tb_fb_rect_writer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fb_rect_writer.sv
// Rectangle-fill writer for the 1-bit framebuffer: turns accepted fill commands
// into one pixel write per clock using addr = x + STRIDE*y, clipped to the memory.
module fb_rect_writer #(
  parameter int STRIDE = 800,
  parameter int ROWS   = 528,
  parameter int ADDR_W = 19,
  parameter int XY_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [XY_W-1:0]   cmd_x0,
  input  logic [XY_W-1:0]   cmd_y0,
  input  logic [XY_W-1:0]   cmd_w,
  input  logic [XY_W-1:0]   cmd_h,
  input  logic              cmd_color,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, FINISH} state_t;

  localparam logic [XY_W:0]     STRIDE_E = (XY_W+1)'(STRIDE);
  localparam logic [XY_W:0]     ROWS_E   = (XY_W+1)'(ROWS);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  state_t            state_q, state_d;
  logic [XY_W-1:0]   x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic              color_q, color_d;
  logic [XY_W-1:0]   x_q, x_d, y_q, y_d;
  logic [XY_W-1:0]   xLast_q, xLast_d, yLast_q, yLast_d;
  logic [ADDR_W-1:0] rowBase_q, rowBase_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic              memData_q, memData_d, memWe_q, memWe_d;
  logic              busy_q, busy_d, done_q, done_d, cmdReady_q, cmdReady_d;

  logic [XY_W:0]     xSum, ySum, xEnd, yEnd;
  logic [ADDR_W-1:0] setupBase;
  logic              emptyCmd;

  // Clipped bounds and first row base, only consumed in SETUP.
  assign xSum      = {1'b0, x0_q} + {1'b0, w_q};
  assign ySum      = {1'b0, y0_q} + {1'b0, h_q};
  assign xEnd      = (xSum > STRIDE_E) ? STRIDE_E : xSum;
  assign yEnd      = (ySum > ROWS_E) ? ROWS_E : ySum;
  assign setupBase = STRIDE_A * ADDR_W'(y0_q);
  assign emptyCmd  = (w_q == '0) || (h_q == '0) ||
                     ({1'b0, x0_q} >= STRIDE_E) || ({1'b0, y0_q} >= ROWS_E);

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    w_d       = w_q;
    h_d       = h_q;
    color_d   = color_q;
    x_d       = x_q;
    y_d       = y_q;
    xLast_d   = xLast_q;
    yLast_d   = yLast_q;
    rowBase_d = rowBase_q;
    memAddr_d = memAddr_q;
    memData_d = memData_q;
    memWe_d   = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmdReady_q) begin
          x0_d    = cmd_x0;
          y0_d    = cmd_y0;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (emptyCmd) begin
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          xLast_d   = XY_W'(xEnd - (XY_W+1)'(1));
          yLast_d   = XY_W'(yEnd - (XY_W+1)'(1));
          x_d       = x0_q;
          y_d       = y0_q;
          rowBase_d = setupBase;
          memAddr_d = setupBase + ADDR_W'(x0_q);
          memData_d = color_q;
          memWe_d   = 1'b1;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        // The registered outputs show pixel (x_q, y_q); here we stage the next one.
        if (x_q == xLast_q && y_q == yLast_q) begin
          done_d  = 1'b1;
          state_d = FINISH;
        end else if (x_q == xLast_q) begin
          x_d       = x0_q;
          y_d       = y_q + XY_W'(1);
          rowBase_d = rowBase_q + STRIDE_A;
          memAddr_d = rowBase_q + STRIDE_A + ADDR_W'(x0_q);
          memWe_d   = 1'b1;
        end else begin
          x_d       = x_q + XY_W'(1);
          memAddr_d = rowBase_q + ADDR_W'(x_q) + ADDR_W'(1);
          memWe_d   = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmdReady_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      xLast_q    <= '0;
      yLast_q    <= '0;
      rowBase_q  <= '0;
      memAddr_q  <= '0;
      memData_q  <= 1'b0;
      memWe_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cmdReady_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      x_q        <= x_d;
      y_q        <= y_d;
      xLast_q    <= xLast_d;
      yLast_q    <= yLast_d;
      rowBase_q  <= rowBase_d;
      memAddr_q  <= memAddr_d;
      memData_q  <= memData_d;
      memWe_q    <= memWe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cmdReady_q <= cmdReady_d;
    end
  end

  assign cmd_ready = cmdReady_q;
  assign mem_addr  = memAddr_q;
  assign mem_data  = memData_q;
  assign mem_we    = memWe_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Randomized and directed bench for fb_rect_writer; expected writes come from a
// row/column enumeration of the clipped rectangle.
module tb_fb_rect_writer;

  localparam int STRIDE = 800;
  localparam int ROWS   = 528;

  logic        clk;
  logic        reset;
  logic        cmdValid;
  logic        cmdReady;
  logic [9:0]  cmdX0, cmdY0, cmdW, cmdH;
  logic        cmdColor;
  logic [18:0] memAddr;
  logic        memData;
  logic        memWe;
  logic        busy;
  logic        done;

  int asserts;
  int failures;
  int expQ[$];

  fb_rect_writer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmdValid),
    .cmd_ready (cmdReady),
    .cmd_x0    (cmdX0),
    .cmd_y0    (cmdY0),
    .cmd_w     (cmdW),
    .cmd_h     (cmdH),
    .cmd_color (cmdColor),
    .mem_addr  (memAddr),
    .mem_data  (memData),
    .mem_we    (memWe),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    asserts++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: every pixel of the rectangle that lies inside the memory, row-major.
  task automatic buildExpected(input int x0, input int y0, input int w, input int h);
    int xe, ye;
    expQ.delete();
    xe = (x0 + w > STRIDE) ? STRIDE : x0 + w;
    ye = (y0 + h > ROWS) ? ROWS : y0 + h;
    for (int y = y0; y < ye; y++)
      for (int x = x0; x < xe; x++)
        expQ.push_back(x + STRIDE * y);
  endtask

  task automatic setFields(input int x0, input int y0, input int w, input int h, input logic c);
    cmdX0    = 10'(x0);
    cmdY0    = 10'(y0);
    cmdW     = 10'(w);
    cmdH     = 10'(h);
    cmdColor = c;
  endtask

  task automatic applyStimulus(input int x0, input int y0, input int w, input int h, input logic c);
    @(negedge clk);
    setFields(x0, y0, w, h, c);
    cmdValid = 1'b1;
    checkOutput("ready_at_start", 32'(cmdReady), 32'd1);
  endtask

  // Expects the command already on the inputs with cmd_ready high; follows it to the
  // first idle cycle, optionally holding cmd_valid with junk and presenting a next command.
  task automatic runCommand(input int x0, input int y0, input int w, input int h, input logic c,
                            input bit holdNext, input int nx0, input int ny0, input int nw,
                            input int nh, input logic nc);
    int e;
    buildExpected(x0, y0, w, h);
    e = expQ.size();
    @(posedge clk);
    for (int k = 1; k <= e + 3; k++) begin
      @(negedge clk);
      if (holdNext) begin
        cmdValid = 1'b1;
        if (k == e + 3) setFields(nx0, ny0, nw, nh, nc);
        else setFields($urandom_range(0, 1023), $urandom_range(0, 1023),
                       $urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom));
      end else begin
        cmdValid = 1'b0;
      end
      checkOutput("done", 32'(done), 32'(k == e + 2));
      checkOutput("busy", 32'(busy), 32'(k <= e + 2));
      checkOutput("cmd_ready", 32'(cmdReady), 32'(k == e + 3));
      checkOutput("mem_we", 32'(memWe), 32'(k >= 2 && k <= e + 1));
      if (k >= 2 && k <= e + 1) begin
        checkOutput("mem_addr", 32'(memAddr), 32'(expQ[k-2]));
        checkOutput("mem_data", 32'(memData), 32'(c));
      end
      if (k == e + 2 && e > 0) checkOutput("addr_hold", 32'(memAddr), 32'(expQ[e-1]));
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rx, ry, rw, rh;
    logic rc;
    asserts  = 0;
    failures = 0;
    reset    = 1'b1;
    cmdValid = 1'b0;
    setFields(0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 32'(cmdReady), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_we", 32'(memWe), 32'd0);
    checkOutput("rst_addr", 32'(memAddr), 32'd0);
    checkOutput("rst_data", 32'(memData), 32'd0);
    reset = 1'b0;

    applyStimulus(10, 2, 3, 2, 1'b1);
    runCommand(10, 2, 3, 2, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    applyStimulus(4, 4, 0, 5, 1'b1);
    runCommand(4, 4, 0, 5, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    applyStimulus(4, 4, 5, 0, 1'b1);
    runCommand(4, 4, 5, 0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    applyStimulus(798, 0, 5, 2, 1'b0);
    runCommand(798, 0, 5, 2, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    applyStimulus(800, 0, 5, 2, 1'b1);
    runCommand(800, 0, 5, 2, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    applyStimulus(0, 527, 2, 3, 1'b1);
    runCommand(0, 527, 2, 3, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    applyStimulus(3, 530, 2, 3, 1'b1);
    runCommand(3, 530, 2, 3, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);

    applyStimulus(100, 50, 2, 2, 1'b1);
    runCommand(100, 50, 2, 2, 1'b1, 1'b1, 200, 60, 3, 1, 1'b0);
    runCommand(200, 60, 3, 1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);

    // Reset lands while the third pixel of a 4x4 fill is on the bus.
    applyStimulus(5, 3, 4, 4, 1'b1);
    buildExpected(5, 3, 4, 4);
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      cmdValid = 1'b0;
      checkOutput("pre_rst_we", 32'(memWe), 32'(k >= 2));
      if (k >= 2) checkOutput("pre_rst_addr", 32'(memAddr), 32'(expQ[k-2]));
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_we", 32'(memWe), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_ready", 32'(cmdReady), 32'd1);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("post_rst_done", 32'(done), 32'd0);
      checkOutput("post_rst_we", 32'(memWe), 32'd0);
    end
    applyStimulus(0, 0, 1, 1, 1'b1);
    runCommand(0, 0, 1, 1, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      rx = $urandom_range(0, 810);
      ry = $urandom_range(0, 540);
      rw = $urandom_range(0, 12);
      rh = $urandom_range(0, 6);
      rc = 1'($urandom);
      applyStimulus(rx, ry, rw, rh, rc);
      runCommand(rx, ry, rw, rh, rc, 1'b0, 0, 0, 0, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
